// File: rtl/pipelined_addsub.sv
// pipelined_addsub: CHUNK-sliced pipelined adder/subtractor with valid/ready handshake and flags
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / CHUNK;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:i*CHUNK]   pa;
        logic [WIDTH-1:i*CHUNK]   pb;
        logic                     pc;
        logic                     pv;
        logic [CHUNK:0]           sl;
        logic [(i+1)*CHUNK-1:0]   ns;
        logic [(i+1)*CHUNK-1:0]   qs;
        logic                     qc;
        logic                     qv;

        if (i == 0) begin : g_first
            assign pa = a;
            assign pb = sub ? ~b : b;
            assign pc = cin ^ sub;
            assign pv = in_valid;
            assign ns = sl[CHUNK-1:0];
        end else begin : g_next
            assign pa = g_stage[i-1].g_fwd.qa;
            assign pb = g_stage[i-1].g_fwd.qb;
            assign pc = g_stage[i-1].qc;
            assign pv = g_stage[i-1].qv;
            assign ns = {sl[CHUNK-1:0], g_stage[i-1].qs};
        end

        assign sl = {1'b0, pa[i*CHUNK +: CHUNK]} + {1'b0, pb[i*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, pc};

        // register this slice's sum, its carry and the valid bit; everything holds on stall
        always_ff @(posedge clk) begin
            if (rst) begin
                qv <= 1'b0;
                qc <= 1'b0;
                qs <= '0;
            end else if (adv) begin
                qv <= pv;
                qc <= sl[CHUNK];
                qs <= ns;
            end
        end

        if (i < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:(i+1)*CHUNK] qa;
            logic [WIDTH-1:(i+1)*CHUNK] qb;

            // carry only the operand slices still waiting to be summed
            always_ff @(posedge clk) begin
                if (rst) begin
                    qa <= '0;
                    qb <= '0;
                end else if (adv) begin
                    qa <= pa[WIDTH-1:(i+1)*CHUNK];
                    qb <= pb[WIDTH-1:(i+1)*CHUNK];
                end
            end
        end else begin : g_out
            // flags come from the final slice and are registered alongside the sum
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf  <= 1'b0;
                    zero <= 1'b0;
                end else if (adv) begin
                    ovf  <= (pa[WIDTH-1] == pb[WIDTH-1]) && (sl[CHUNK-1] != pa[WIDTH-1]);
                    zero <= ~|ns;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].qv;
    assign sum       = g_stage[STAGES-1].qs;
    assign cout      = g_stage[STAGES-1].qc;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scenario tasks checking pipelined_addsub against an arithmetic reference model
module tb_pipelined_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // reference: exact signed/unsigned arithmetic, packed as {zero, ovf, cout, sum}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
        longint sx, sy, ux, uy, ci, e;
        logic [31:0] r;
        logic co, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        ci = longint'({63'b0, c});
        e  = s ? sx - sy - ci : sx + sy + ci;
        ov = (e > 64'sd2147483647) || (e < -64'sd2147483648);
        co = s ? (ux >= uy + ci) : (ux + uy + ci > 64'sd4294967295);
        r  = e[31:0];
        return {r == 32'd0, ov, co, r};
    endfunction

    function automatic logic [31:0] rnd_operand();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? 32'h0 : k == 1 ? 32'hFFFFFFFF : k == 2 ? 32'h7FFFFFFF : k == 3 ? 32'h80000000 : $urandom;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        sub = 1'b0;
        cin = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during got=%b exp=1", in_ready); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if ({zero, ovf, cout, sum} !== 35'd0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {zero, ovf, cout, sum}); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic s, input logic c,
                           input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        logic early;
        early = 1'b0;
        a = x;
        b = y;
        sub = s;
        cin = c;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept in_ready got=%b exp=1", name, in_ready); end
        next_cycle();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) early = 1'b1;
            next_cycle();
        end
        checks++;
        if (early) begin errors++; $display("FAIL %s_latency out_valid early got=1 exp=0", name); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid got=%b exp=1", name, out_valid); end
        checks++;
        if (sum !== es) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, sum, es); end
        checks++;
        if ({cout, ovf, zero} !== {ec, eo, ez}) begin
            errors++;
            $display("FAIL %s_flags cout/ovf/zero got=%b%b%b exp=%b%b%b", name, cout, ovf, zero, ec, eo, ez);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int sent, recv;
        logic took, stall_seen;
        logic [34:0] held, got, e;
        sent = 0;
        recv = 0;
        stall_seen = 1'b0;
        held = '0;
        exp_q.delete();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            if (sent < 8 && !in_valid) begin
                a = rnd_operand();
                b = rnd_operand();
                sub = 1'($urandom_range(0, 1));
                cin = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            out_ready = !(cyc >= 4 && cyc <= 6);
            @(negedge clk);
            got = {zero, ovf, cout, sum};
            if (!out_ready) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stall cyc=%0d in_ready/out_valid got=%b%b exp=01", cyc, in_ready, out_valid);
                end
                if (stall_seen) begin
                    checks++;
                    if (got !== held) begin errors++; $display("FAIL b2b_held cyc=%0d got=%h exp=%h", cyc, got, held); end
                end
                held = got;
                stall_seen = 1'b1;
            end
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back(model(a, b, sub, cin));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL b2b_result n=%0d got=%h exp=%h", recv, got, e); end
                end
                recv++;
            end
            next_cycle();
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count recv=%0d pending=%0d exp recv=8 pending=0", recv, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        logic [31:0] x, y;
        logic s, c;
        logic [34:0] e;
        bad = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            next_cycle();
        end
        rst = 1'b1;
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        next_cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({zero, ovf, cout, sum} !== 35'd0) begin errors++; $display("FAIL midrst_fields got=%h exp=0", {zero, ovf, cout, sum}); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad = 1'b1;
            next_cycle();
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midrst_flush out_valid got=1 exp=0"); end
        x = rnd_operand();
        y = rnd_operand();
        s = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        e = model(x, y, s, c);
        test_op("post_reset", x, y, s, c, e[31:0], e[32], e[33], e[34]);
    endtask

    task automatic test_random();
        logic took, prev_stall;
        logic [34:0] prev, got, e;
        int recv;
        recv = 0;
        prev_stall = 1'b0;
        prev = '0;
        exp_q.delete();
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_valid) begin
                a = rnd_operand();
                b = rnd_operand();
                sub = 1'($urandom_range(0, 1));
                cin = 1'($urandom_range(0, 1));
                in_valid = $urandom_range(0, 9) < 7;
            end
            out_ready = $urandom_range(0, 9) < 7;
            @(negedge clk);
            got = {zero, ovf, cout, sum};
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !out_valid || out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    errors++;
                    $display("FAIL rnd_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, got, prev);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = got;
            took = in_valid && in_ready;
            if (took) exp_q.push_back(model(a, b, sub, cin));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin errors++; $display("FAIL rnd_result n=%0d got=%h exp=%h", recv, got, e); end
                end
                recv++;
            end
            next_cycle();
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = {zero, ovf, cout, sum};
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin errors++; $display("FAIL rnd_drain n=%0d got=%h exp=%h", recv, got, e); end
                recv++;
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout pending=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_op("add_basic", 32'd5, 32'd3, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0);
        test_op("add_wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        test_op("add_ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        test_op("sub_neg", 32'd3, 32'd5, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        test_op("sub_ovf", 32'h80000000, 32'd1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        test_op("carry_chain", 32'h00FFFFFF, 32'd1, 1'b0, 1'b1, 32'h01000001, 1'b0, 1'b0, 1'b0);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
